inst_mem: RTL and testbench

- Word-addressed instruction ROM/RAM for the single-cycle RV32 core; holds the program image and returns the 32-bit instruction at the current PC.
- The core drives the word index `pc[7:2]` and uses the instruction combinationally in the same cycle.
- The program is preloaded at time zero by hierarchical assignment to the internal array, or through an optional synchronous load port.

---
 rtl/inst_mem.sv | 41 ++++
 tb/tb_inst_mem.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inst_mem.sv
// Word-addressed instruction store for the single-cycle RV32 core.
// Zero-latency read at the PC word index, plus an optional synchronous load port.
module inst_mem #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              w_clk,
  output logic [DATA_W-1:0] w_inst,
  input  logic              w_rst,
  input  logic              w_load_en,
  input  logic [ADDR_W-1:0] w_load_addr,
  input  logic [DATA_W-1:0] w_load_data
);

  // Program image; testbenches preload it hierarchically through the .mem path.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] w_inst_s;

  // Combinational read; reset presents an all-zero word, which the core treats as a no-op.
  always_comb begin
    w_inst_s = '0;
    if (w_rst) begin
      w_inst_s = '0;
    end else begin
      w_inst_s = mem[w_addr];
    end
  end

  assign w_inst = w_inst_s;

  // Load-port write; reset discards the write but never clears the stored image.
  always_ff @(posedge w_clk) begin
    if (!w_rst && w_load_en) begin
      mem[w_load_addr] <= w_load_data;
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem: stimulus pushes expected words from a flat
// array model, a separate monitor pops and compares them against w_inst.
module tb_inst_mem;

  logic        w_clk;
  logic        w_rst;
  logic [5:0]  w_addr;
  logic [31:0] w_inst;
  logic        w_load_en;
  logic [5:0]  w_load_addr;
  logic [31:0] w_load_data;

  inst_mem dut (
    .w_addr      (w_addr),
    .w_clk       (w_clk),
    .w_inst      (w_inst),
    .w_rst       (w_rst),
    .w_load_en   (w_load_en),
    .w_load_addr (w_load_addr),
    .w_load_data (w_load_data)
  );

  typedef struct {
    string       name;
    logic [5:0]  addr;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [64];
  int          checks = 0;
  int          errors = 0;
  event        sample_ev;

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Expected word from the model: zero under reset, otherwise the stored word.
  task automatic observe(input string name);
    exp_t e;
    #1;
    e.name = name;
    e.addr = w_addr;
    e.exp  = w_rst ? 32'h0 : model[w_addr];
    sb_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge w_clk);
    if (!w_rst && w_load_en) model[w_load_addr] = w_load_data;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    @(negedge w_clk);
    w_load_en = 1'b1; w_load_addr = a; w_load_data = d;
    clock_edge();
    @(negedge w_clk);
    w_load_en = 1'b0;
  endtask

  // Monitor: compare each presented output with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got=%h", w_inst);
      end else begin
        e = sb_q.pop_front();
        if (w_inst !== e.exp) begin
          errors++;
          $display("FAIL %s addr=%0d got=%h exp=%h", e.name, e.addr, w_inst, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [8:0] pc;
    int pcs [5] = '{0, 4, 8, 252, 256};
    logic [5:0] ra;

    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    w_rst = 1'b0; w_addr = 6'd0; w_load_en = 1'b0;
    w_load_addr = 6'd0; w_load_data = 32'h0;
    #2;

    // Fresh contents are all zero.
    w_addr = 6'd17;
    observe("fresh_17");
    for (int i = 0; i < 64; i++) begin
      w_addr = 6'(i);
      observe("fresh_sweep");
    end

    w_rst = 1'b1; w_addr = 6'd17;
    observe("reset_out");
    w_rst = 1'b0;

    // Hierarchical preload and clockless address stepping.
    dut.mem[0] = 32'h00500093; model[0] = 32'h00500093;
    dut.mem[1] = 32'h00308113; model[1] = 32'h00308113;
    w_addr = 6'd0;
    observe("preload_0");
    w_addr = 6'd1;
    observe("preload_1");

    // Read-during-write on the same index.
    @(negedge w_clk);
    w_load_en = 1'b1; w_load_addr = 6'd5; w_load_data = 32'hDEADBEEF; w_addr = 6'd5;
    observe("rdw_before");
    clock_edge();
    observe("rdw_after");
    @(negedge w_clk);
    w_load_en = 1'b0;
    w_addr = 6'd4; observe("neighbour_4");
    w_addr = 6'd6; observe("neighbour_6");

    // Reset blanks the output but preserves contents.
    load_word(6'd3, 32'h12345678);
    w_rst = 1'b1; w_addr = 6'd3;
    observe("rst_blank_3");
    w_rst = 1'b0;
    observe("rst_keep_3");

    // A write under reset is discarded.
    load_word(6'd2, 32'h11112222);
    @(negedge w_clk);
    w_rst = 1'b1; w_load_en = 1'b1; w_load_addr = 6'd2; w_load_data = 32'hA5A5A5A5;
    w_addr = 6'd2;
    observe("rst_load_out");
    clock_edge();
    @(negedge w_clk);
    w_rst = 1'b0; w_load_en = 1'b0;
    observe("rst_load_discard");

    // Core-style PC drive, including the wrap past byte 255.
    load_word(6'd63, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      pc = 9'(pcs[i]);
      w_addr = pc[7:2];
      observe("pc_drive");
    end

    // Randomised mix of loads, resets and reads around each edge.
    for (int n = 0; n < 300; n++) begin
      @(negedge w_clk);
      w_rst       = ($urandom_range(7) == 0);
      w_load_en   = $urandom_range(1);
      w_load_addr = 6'($urandom_range(63));
      w_load_data = $urandom;
      ra          = 6'($urandom_range(63));
      w_addr      = $urandom_range(1) ? w_load_addr : ra;
      observe("rand_pre");
      clock_edge();
      observe("rand_post");
    end
    @(negedge w_clk);
    w_load_en = 1'b0; w_rst = 1'b0;

    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
